// File: rtl/dht11_host_ctrl_if.sv
// DHT11 host controller bus bundle: request handshake, raw bus level,
// open-drain enable and decoded result bytes.
interface dht11_host_ctrl_if;
  logic       start;
  logic       data_i;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;

  modport master (
    output start, data_i,
    input  data_oe, busy, done, err, err_code,
    input  hum_int, hum_dec, temp_int, temp_dec
  );

  modport slave (
    input  start, data_i,
    output data_oe, busy, done, err, err_code,
    output hum_int, hum_dec, temp_int, temp_dec
  );
endinterface

// File: rtl/dht11_host_ctrl.sv
// Single-wire DHT11 host: start request, response preamble check,
// 40-bit pulse-width decode, checksum verify and cooldown.
module dht11_host_ctrl #(
  parameter int unsigned REQ_LOW_CYC   = 180,
  parameter int unsigned RESP_WAIT_CYC = 600,
  parameter int unsigned TIMEOUT_CYC   = 1000,
  parameter int unsigned BIT_THRESH    = 470,
  parameter int unsigned COOLDOWN_CYC  = 2000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dht11_host_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_LOW,
    S_REQ_REL,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_COOL
  } state_e;

  localparam logic [CNT_W-1:0] REQ_END  = CNT_W'(REQ_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_END = CNT_W'(RESP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_END = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(BIT_THRESH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_idx_q, bit_idx_d;
  logic [39:0]      sh_q, sh_d;
  logic [31:0]      bytes_q, bytes_d;
  logic [1:0]       code_q, code_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             s1_q, s2_q, prev_q;

  logic       rise, fall, tmo, sum_ok;
  logic [7:0] sum;

  assign rise   = s2_q & ~prev_q;
  assign fall   = ~s2_q & prev_q;
  assign tmo    = (cnt_q == TMO_END);
  assign sum    = sh_q[39:32] + sh_q[31:24] + sh_q[23:16] + sh_q[15:8];
  assign sum_ok = (sum == sh_q[7:0]);

  // Sync flops reset high so an idle pulled-up bus shows no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      bytes_q   <= '0;
      code_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      bytes_q   <= bytes_d;
      code_q    <= code_d;
      done_q    <= done_d;
      err_q     <= err_d;
      s1_q      <= bus.data_i;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = S_REQ_LOW;
      S_REQ_LOW:   if (cnt_q == REQ_END) state_d = S_REQ_REL;
      S_REQ_REL: begin
        if (fall) state_d = S_RESP_LOW;
        else if (cnt_q == RESP_END) state_d = S_COOL;
      end
      S_RESP_LOW: begin
        if (rise) state_d = S_RESP_HIGH;
        else if (tmo) state_d = S_COOL;
      end
      S_RESP_HIGH: begin
        if (fall) state_d = S_BIT_LOW;
        else if (tmo) state_d = S_COOL;
      end
      S_BIT_LOW: begin
        if (rise) state_d = S_BIT_HIGH;
        else if (tmo) state_d = S_COOL;
      end
      S_BIT_HIGH: begin
        if (fall) state_d = (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
        else if (tmo) state_d = S_COOL;
      end
      S_CHECK:     state_d = S_COOL;
      S_COOL:      if (cnt_q == COOL_END) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    bytes_d   = bytes_q;
    code_d    = code_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_d == state_q && state_q != S_IDLE) cnt_d = cnt_q + CNT_W'(1);
    // Any jump to cooldown from a bus phase is a failure of that phase.
    if (state_d == S_COOL && state_q != S_CHECK && state_q != S_COOL) begin
      err_d  = 1'b1;
      code_d = (state_q == S_REQ_REL) ? 2'd1 : 2'd2;
    end
    case (state_q)
      S_IDLE:      if (bus.start) code_d = 2'd0;
      S_RESP_HIGH: if (fall) bit_idx_d = '0;
      S_BIT_HIGH: begin
        if (fall) begin
          sh_d      = {sh_q[38:0], (cnt_q > THRESH)};
          bit_idx_d = bit_idx_q + 6'd1;
        end
      end
      S_CHECK: begin
        if (sum_ok) begin
          bytes_d = sh_q[39:8];
          done_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      default: ;
    endcase
  end

  assign bus.data_oe  = (state_q == S_REQ_LOW);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;
  assign bus.hum_int  = bytes_q[31:24];
  assign bus.hum_dec  = bytes_q[23:16];
  assign bus.temp_int = bytes_q[15:8];
  assign bus.temp_dec = bytes_q[7:0];

endmodule

// File: tb/tb_dht11_host_ctrl.sv
// Bench for dht11_host_ctrl: open-drain sensor model with jittered timing,
// outcome scoreboard and cooldown/timeout latency checks.
module tb_dht11_host_ctrl;

  localparam int REQ_LOW_CYC   = 180;
  localparam int RESP_WAIT_CYC = 600;
  localparam int TIMEOUT_CYC   = 1000;
  localparam int COOLDOWN_CYC  = 2000;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] bytes;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sens_low = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   ev_cyc = 0;
  int   last_fall = 0;
  int   rel_cyc = 0;
  logic [31:0] last_good = '0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_host_ctrl_if bus();
  assign bus.data_i = ~(bus.data_oe | sens_low);

  dht11_host_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] out_bytes();
    return {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec};
  endfunction

  // Outcome of one read from frame content and sensor behaviour alone.
  function automatic void predict(input logic [39:0] f, input int nbits,
                                  input bit present);
    exp_t e;
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    e.is_err = 1'b1;
    if (!present) e.code = 2'd1;
    else if (nbits < 40) e.code = 2'd2;
    else if (s != f[7:0]) e.code = 2'd3;
    else begin
      e.is_err  = 1'b0;
      e.code    = 2'd0;
      last_good = f[39:8];
    end
    e.bytes = last_good;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (bus.done || bus.err)) begin
      ev_cyc = cyc;
      chk("done_err_excl", {63'd0, bus.done & bus.err}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: done=%0b err=%0b code=%0d",
                 bus.done, bus.err, bus.err_code);
      end else begin
        e = q.pop_front();
        chk("event_kind", {63'd0, bus.err}, {63'd0, e.is_err});
        chk("err_code", {62'd0, bus.err_code}, {62'd0, e.code});
        chk("bytes", {32'd0, out_bytes()}, {32'd0, e.bytes});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f, input int nbits,
                            input bit present, input bit inj,
                            input int rst_bit);
    int n;
    n = 0;
    while (!bus.data_oe && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.data_oe && n < 1000) begin
      n++;
      bus.start = inj && (n == 50);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("oe_low_cycles", 64'(n), 64'(REQ_LOW_CYC));
    rel_cyc = cyc;
    if (!present) return;
    hold($urandom_range(20, 40));
    sens_low = 1'b1;
    hold($urandom_range(75, 85));
    sens_low = 1'b0;
    hold($urandom_range(75, 85));
    for (int i = 0; i < nbits; i++) begin
      sens_low = 1'b1;
      hold($urandom_range(45, 55));
      sens_low = 1'b0;
      if (i == rst_bit) begin
        hold(100);
        rst_n = 1'b0;
        #1;
        chk("rst_oe", {63'd0, bus.data_oe}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done_err", {62'd0, bus.done, bus.err}, 64'd0);
        chk("rst_bytes", {32'd0, out_bytes()}, 64'd0);
        q.delete();
        last_good = '0;
        hold(5);
        rst_n = 1'b1;
        return;
      end
      if (f[39-i]) hold($urandom_range(620, 720));
      else hold($urandom_range(200, 280));
    end
    sens_low = 1'b1;
    last_fall = cyc;
    if (nbits == 40) hold($urandom_range(45, 55));
    else hold(TIMEOUT_CYC + 50);
    sens_low = 1'b0;
  endtask

  task automatic check_cooldown(input bit inj);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40000) begin
      @(negedge clk);
      n++;
      if (bus.done || bus.err) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL event_wait: no done/err within %0d cycles", n);
      return;
    end
    n = 0;
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
      bus.start = inj && (n == 100);
    end
    bus.start = 1'b0;
    chk("cooldown_len", 64'(n), 64'(COOLDOWN_CYC));
    hold(20);
    chk("stays_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic logic [39:0] mk(input logic [7:0] h, input logic [7:0] hd,
                                     input logic [7:0] t, input logic [7:0] td,
                                     input logic [7:0] c);
    return {h, hd, t, td, c};
  endfunction

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f;
    logic [7:0]  h, hd, t, td;
    bus.start = 1'b0;
    hold(5);
    chk("reset_oe", {63'd0, bus.data_oe}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done_err", {62'd0, bus.done, bus.err}, 64'd0);
    chk("reset_code", {62'd0, bus.err_code}, 64'd0);
    chk("reset_bytes", {32'd0, out_bytes()}, 64'd0);
    rst_n = 1'b1;
    hold(5);

    f = mk(8'h2D, 8'h00, 8'h17, 8'h05, 8'h49);
    predict(f, 40, 1'b0);
    pulse_start();
    fork
      send_frame(f, 40, 1'b0, 1'b0, -1);
      check_cooldown(1'b0);
    join
    chk("noresp_latency",
        {63'd0, (ev_cyc - rel_cyc >= RESP_WAIT_CYC - 2) &&
                (ev_cyc - rel_cyc <= RESP_WAIT_CYC + 4)}, 64'd1);

    predict(f, 40, 1'b1);
    pulse_start();
    fork
      send_frame(f, 40, 1'b1, 1'b1, -1);
      check_cooldown(1'b1);
    join

    f = mk(8'h2D, 8'h00, 8'h17, 8'h05, 8'h4A);
    predict(f, 40, 1'b1);
    pulse_start();
    fork
      send_frame(f, 40, 1'b1, 1'b0, -1);
      check_cooldown(1'b0);
    join

    f = mk(8'h2D, 8'h00, 8'h17, 8'h05, 8'h49);
    predict(f, 18, 1'b1);
    pulse_start();
    fork
      send_frame(f, 18, 1'b1, 1'b0, -1);
      check_cooldown(1'b0);
    join
    chk("timeout_latency",
        {63'd0, (ev_cyc - last_fall >= TIMEOUT_CYC) &&
                (ev_cyc - last_fall <= TIMEOUT_CYC + 8)}, 64'd1);

    predict(f, 40, 1'b1);
    pulse_start();
    send_frame(f, 40, 1'b1, 1'b0, 20);
    hold(10);
    chk("post_rst_idle", {63'd0, bus.busy}, 64'd0);

    h  = 8'($urandom_range(20, 90));
    hd = 8'($urandom_range(0, 9));
    t  = 8'($urandom_range(0, 50));
    td = 8'($urandom_range(0, 9));
    f = mk(h, hd, t, td, h + hd + t + td);
    predict(f, 40, 1'b1);
    pulse_start();
    fork
      send_frame(f, 40, 1'b1, 1'b0, -1);
      check_cooldown(1'b0);
    join

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dht11_host_ctrl.md
Name: dht11_host_ctrl

Overview:
Synthesizable single-wire host controller for the DHT11 humidity/temperature sensor bus. On a start request it drives the bus low for the request period and releases it. It then checks the sensor response preamble and times 40 data bits. It verifies the checksum and presents the decoded bytes with done/err pulses. The bus is open-drain: the block only ever pulls low or releases, and the pad/pull-up sit outside.

Parameters:
REQ_LOW_CYC, 180, cycles data_oe held high (bus pulled low) for the start request
RESP_WAIT_CYC, 600, max cycles after release to see sensor pull bus low
TIMEOUT_CYC, 1000, max cycles any single response/bit phase may last
BIT_THRESH, 470, high-phase length > BIT_THRESH decodes as 1, else 0
COOLDOWN_CYC, 2000, enforced idle cycles after any transaction end
CNT_W, 16, phase counter width; must hold max(all cycle params)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a read; ignored while busy
data_i  in  1  raw bus level (asynchronous to clk)
data_oe  out  1  1 = pull bus low, 0 = release (high-Z)
busy  out  1  high from accepted start until cooldown ends
done  out  1  one-cycle pulse: frame received, checksum good, outputs updated
err  out  1  one-cycle pulse: transaction failed
err_code  out  2  0 none, 1 no response, 2 mid-frame timeout, 3 checksum mismatch
hum_int  out  8  humidity integer byte
hum_dec  out  8  humidity decimal byte
temp_int  out  8  temperature integer byte
temp_dec  out  8  temperature decimal byte

Behaviour:
- Reset (async, immediate): state IDLE, data_oe=0, busy=0, done=0, err=0, err_code=0, all data bytes 0, counters 0.
- data_i passes a 2-flop synchronizer. Edges are detected on the synchronized value against its previous-cycle value. Edge-to-action latency is 3 cycles.
- IDLE: when start=1, go to REQ_LOW, set busy=1, clear err_code, clear counter.
- REQ_LOW: data_oe=1 for exactly REQ_LOW_CYC cycles, then data_oe=0 and go to REQ_REL.
- REQ_REL: a falling edge goes to RESP_LOW. If counter reaches RESP_WAIT_CYC first: err, code 1.
- RESP_LOW: a rising edge goes to RESP_HIGH.
- RESP_HIGH: a falling edge goes to BIT_LOW, with bit_idx=0.
- BIT_LOW: a rising edge clears the counter and goes to BIT_HIGH.
- BIT_HIGH: counter increments each cycle. A falling edge shifts the bit (counter > BIT_THRESH) into a 40-bit shift register, MSB first.
  - If bit_idx==39, go to CHECK.
  - Otherwise bit_idx+1 and go to BIT_LOW.
- Any of RESP_LOW/RESP_HIGH/BIT_LOW/BIT_HIGH: if counter reaches TIMEOUT_CYC without the expected edge: err, code 2.
- Counter clears on every state transition.
- Frame order: hum_int, hum_dec, temp_int, temp_dec, checksum.
- CHECK (1 cycle): checksum must equal (sum of the four bytes) mod 256, with an 8-bit truncating add.
  - Match: load the four output bytes, pulse done.
  - Mismatch: err, code 3; output bytes are left unchanged.
- Error path: err pulses one cycle. err_code holds until the next accepted start. Data bytes keep their previous values. data_oe is 0.
- done and err then go to COOLDOWN. They are never high in the same cycle.
- COOLDOWN: busy stays 1 for COOLDOWN_CYC cycles, then IDLE with busy=0. A start during cooldown is dropped, not queued.
- A start on the same cycle busy falls is ignored. It is accepted only from IDLE with busy=0.
- data_oe is high only in REQ_LOW, so the host never drives while the sensor drives.

Test Plan:
- Bench sensor model replies with frame 0x2D,0x00,0x17,0x05,0x49 (0-bit high 240 cycles, 1-bit high 700) after start -> done pulses once, hum_int=0x2D, hum_dec=0x00, temp_int=0x17, temp_dec=0x05, err_code=0, busy drops COOLDOWN_CYC cycles after done.
- Start with no sensor (bus pulled up) -> data_oe high exactly 180 cycles; err pulses with err_code=1 about 600 cycles after release; data bytes stay 0.
- Same frame with checksum 0x4A -> err, err_code=3. Previous good values (0x2D,0x00,0x17,0x05) are retained and done is never asserted.
- Sensor stops driving after bit 17 (bus stuck low) -> err_code=2 TIMEOUT_CYC cycles after last edge, then COOLDOWN, then IDLE.
- Start pulses during REQ_LOW and during COOLDOWN -> ignored; exactly one transaction runs, with one done.
- rst_n asserted in BIT_HIGH at bit 20 -> data_oe, busy, done, err go 0 immediately and bytes are cleared; a fresh start after reset decodes the frame correctly.
